status_register: RTL and testbench

//  Architectural flags register sitting directly downstream of the ALU/zero-flag logic.
//  - Derives Z (result==0, same rule as zero_flag) and N (result MSB) from each ALU result.
//  - Latches Z/N/C/V under a per-flag mask.
//  - Keeps a small save/restore stack of flags for interrupt entry/exit.
//  - Evaluates branch conditions for the fetch/branch unit.

---
 rtl/status_register.sv | 152 +++++++++++++++
 tb/tb_status_register.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/status_register.sv
// Z/N/C/V flags register with masked update, save/restore stack and branch conditions.
// Optional sticky overflow flag enabled by defining STATUS_STICKY_OVERFLOW_EN.
module status_register #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic [3:0]       flag_mask,
    input  logic             push,
    input  logic             pop,
    input  logic [2:0]       cond,
    output logic [3:0]       flags,
    output logic             cond_true,
    output logic             stack_empty,
    output logic             stack_full,
`ifdef STATUS_STICKY_OVERFLOW_EN
    output logic             so_flag,
    input  logic             clr_so,
`endif
    output logic             stack_error
);

    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PW-1:0] count;
    logic [PW-1:0] count_n;
    logic [3:0]    mem [2**AW];
    logic [AW-1:0] top_a;
    logic [AW-1:0] cnt_a;
    logic [AW-1:0] waddr;
    logic [3:0]    alu_flags;
    logic [3:0]    upd;
    logic [3:0]    flags_n;
    logic          alu_apply;
    logic          restore;
    logic          we;
    logic          err_set;

    assign stack_empty = (count == '0);
    assign stack_full  = (count == PW'(STACK_DEPTH));
    assign top_a       = AW'(count - 1'b1);
    assign cnt_a       = AW'(count);

    assign alu_flags = {~|alu_result, alu_result[WIDTH-1],
                        alu_carry, alu_overflow};
    assign upd = (flag_mask & alu_flags) | (~flag_mask & flags);

    always_comb begin
        alu_apply = 1'b0;
        restore   = 1'b0;
        we        = 1'b0;
        waddr     = cnt_a;
        err_set   = 1'b0;
        count_n   = count;
        if (push && pop) begin
            // swap: old flags take the top slot, count unchanged
            if (stack_empty) begin
                err_set = 1'b1;
            end else begin
                restore = 1'b1;
                we      = 1'b1;
                waddr   = top_a;
            end
        end else if (pop) begin
            if (stack_empty) begin
                err_set   = 1'b1;
                alu_apply = alu_valid;
            end else begin
                restore = 1'b1;
                count_n = count - 1'b1;
            end
        end else if (push) begin
            if (stack_full) begin
                err_set = 1'b1;
            end else begin
                we        = 1'b1;
                count_n   = count + 1'b1;
                alu_apply = alu_valid;
            end
        end else begin
            alu_apply = alu_valid;
        end
    end

    always_comb begin
        flags_n = flags;
        if (restore) begin
            flags_n = mem[top_a];
        end else if (alu_apply) begin
            flags_n = upd;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags       <= 4'b0000;
            count       <= '0;
            stack_error <= 1'b0;
        end else begin
            flags   <= flags_n;
            count   <= count_n;
            if (err_set) begin
                stack_error <= 1'b1;
            end
        end
    end

    // stack contents need no reset; count gates every read
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= flags;
        end
    end

`ifdef STATUS_STICKY_OVERFLOW_EN
    logic so_set;
    assign so_set = (restore && mem[top_a][0]) ||
                    (alu_apply && flag_mask[0] && alu_overflow);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            so_flag <= 1'b0;
        end else if (so_set) begin
            so_flag <= 1'b1;
        end else if (clr_so) begin
            so_flag <= 1'b0;
        end
    end
`endif

    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = flags[3];
            3'b010: cond_true = ~flags[3];
            3'b011: cond_true = flags[1];
            3'b100: cond_true = ~flags[1];
            3'b101: cond_true = flags[2];
            3'b110: cond_true = flags[0];
            3'b111: cond_true = flags[2] ^ flags[0];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_status_register.sv
// Scoreboard bench for status_register: stimulus queues expectations,
// a monitor compares one entry after every clock edge.
module tb_status_register;

    logic       clock = 1'b0;
    logic       reset;
    logic       alu_valid;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic [3:0] flag_mask;
    logic       push;
    logic       pop;
    logic [2:0] cond;
    logic [3:0] flags;
    logic       cond_true;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_error;
`ifdef STATUS_STICKY_OVERFLOW_EN
    logic       so_flag;
    logic       clr_so;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] f;
        logic       e;
        logic       fu;
        logic       er;
        logic       ct;
        logic       sc;
        logic       so;
        string      nm;
    } exp_t;

    exp_t q[$];
    logic so_chk = 1'b0;
    logic so_exp = 1'b0;

    status_register #(.WIDTH(8), .STACK_DEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .alu_valid(alu_valid),
        .alu_result(alu_result),
        .alu_carry(alu_carry),
        .alu_overflow(alu_overflow),
        .flag_mask(flag_mask),
        .push(push),
        .pop(pop),
        .cond(cond),
        .flags(flags),
        .cond_true(cond_true),
        .stack_empty(stack_empty),
        .stack_full(stack_full),
`ifdef STATUS_STICKY_OVERFLOW_EN
        .so_flag(so_flag),
        .clr_so(clr_so),
`endif
        .stack_error(stack_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid    = 1'b0;
        alu_result   = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        flag_mask    = 4'b0000;
        push         = 1'b0;
        pop          = 1'b0;
`ifdef STATUS_STICKY_OVERFLOW_EN
        clr_so       = 1'b0;
`endif
    endtask

    // Drive one cycle at negedge; expectation holds after the next posedge.
    task automatic step(input logic av, input logic [7:0] res,
                        input logic c, input logic v,
                        input logic [3:0] m, input logic ps,
                        input logic pp, input logic [2:0] cd,
                        input logic [3:0] ef, input logic ee,
                        input logic efu, input logic eer,
                        input logic ect, input string nm);
        exp_t x;
        alu_valid    = av;
        alu_result   = res;
        alu_carry    = c;
        alu_overflow = v;
        flag_mask    = m;
        push         = ps;
        pop          = pp;
        cond         = cd;
        x.f  = ef;
        x.e  = ee;
        x.fu = efu;
        x.er = eer;
        x.ct = ect;
        x.sc = so_chk;
        x.so = so_exp;
        x.nm = nm;
        q.push_back(x);
        @(negedge clock);
        idle();
    endtask

    // Asynchronous reset away from any clock edge, checked before the next edge.
    task automatic mid_reset(input string nm);
        #2;
        reset = 1'b1;
        #1;
        check({nm, "_rst"}, {flags, stack_empty, stack_full, stack_error, 1'b0},
              {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
        #1;
        reset = 1'b0;
        @(negedge clock);
    endtask

    always @(posedge clock) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            check(x.nm,
                  {flags, stack_empty, stack_full, stack_error, cond_true},
                  {x.f, x.e, x.fu, x.er, x.ct});
`ifdef STATUS_STICKY_OVERFLOW_EN
            if (x.sc) begin
                check({x.nm, "_so"}, {7'd0, so_flag}, {7'd0, x.so});
            end
`endif
        end
    end

    initial begin
        idle();
        cond  = 3'b000;
        reset = 1'b1;
        @(negedge clock);
        check("reset", {flags, stack_empty, stack_full, stack_error, 1'b0},
              {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        @(negedge clock);

        //    av  res    c  v  mask   ps pp cond    flags  e  fu er ct
        step(1, 8'h00, 1, 0, 4'hF, 0, 0, 3'b001, 4'b1010, 1, 0, 0, 1, "upd_zero");
        step(1, 8'h80, 0, 0, 4'h4, 0, 0, 3'b101, 4'b1110, 1, 0, 0, 1, "mask_n");
        step(1, 8'h00, 1, 0, 4'hF, 0, 0, 3'b010, 4'b1010, 1, 0, 0, 0, "ne");
        step(0, 8'h00, 0, 0, 4'h0, 1, 0, 3'b011, 4'b1010, 0, 0, 0, 1, "push1");
        step(1, 8'h01, 0, 1, 4'hF, 0, 0, 3'b110, 4'b0001, 0, 0, 0, 1, "upd_v");
        step(1, 8'h00, 0, 0, 4'hF, 0, 1, 3'b111, 4'b1010, 1, 0, 0, 0, "pop_ovr");

        step(1, 8'h01, 0, 1, 4'hF, 1, 0, 3'b000, 4'b0001, 0, 0, 0, 1, "fill1");
        step(1, 8'h80, 1, 0, 4'hF, 1, 0, 3'b000, 4'b0110, 0, 0, 0, 1, "fill2");
        step(1, 8'h00, 0, 1, 4'hF, 1, 0, 3'b000, 4'b1001, 0, 0, 0, 1, "fill3");
        step(1, 8'h81, 1, 1, 4'hF, 1, 0, 3'b111, 4'b0111, 0, 1, 0, 0, "fill4");
        step(0, 8'h00, 0, 0, 4'h0, 1, 0, 3'b111, 4'b0111, 0, 1, 1, 0, "push_full");
        step(0, 8'h00, 0, 0, 4'h0, 0, 1, 3'b100, 4'b1001, 0, 0, 1, 1, "lifo1");
        step(0, 8'h00, 0, 0, 4'h0, 0, 1, 3'b000, 4'b0110, 0, 0, 1, 1, "lifo2");
        step(0, 8'h00, 0, 0, 4'h0, 0, 1, 3'b011, 4'b0001, 0, 0, 1, 0, "lifo3");
        step(0, 8'h00, 0, 0, 4'h0, 0, 1, 3'b001, 4'b1010, 1, 0, 1, 1, "lifo4");

        mid_reset("mid");
        step(1, 8'h00, 0, 0, 4'h8, 0, 1, 3'b001, 4'b1000, 1, 0, 1, 1, "pop_empty");
        step(1, 8'h80, 0, 0, 4'hF, 1, 0, 3'b101, 4'b0100, 0, 0, 1, 1, "push_sw");
        step(1, 8'h00, 1, 1, 4'hF, 1, 1, 3'b001, 4'b1000, 0, 0, 1, 1, "swap");
        step(0, 8'h00, 0, 0, 4'h0, 0, 1, 3'b001, 4'b0100, 1, 0, 1, 0, "pop_swap");

        mid_reset("mid2");
        step(1, 8'h00, 1, 1, 4'hF, 1, 1, 3'b000, 4'b0000, 1, 0, 1, 1, "pp_empty");

`ifdef STATUS_STICKY_OVERFLOW_EN
        mid_reset("mid3");
        so_chk = 1'b1;
        so_exp = 1'b1;
        step(1, 8'h01, 0, 1, 4'hF, 0, 0, 3'b110, 4'b0001, 1, 0, 0, 1, "so_set");
        step(1, 8'h01, 0, 0, 4'hF, 0, 0, 3'b110, 4'b0000, 1, 0, 0, 0, "so_hold");
        clr_so = 1'b1;
        so_exp = 1'b0;
        step(0, 8'h00, 0, 0, 4'h0, 0, 0, 3'b000, 4'b0000, 1, 0, 0, 1, "so_clr");
        clr_so = 1'b1;
        so_exp = 1'b1;
        step(1, 8'h01, 0, 1, 4'h1, 0, 0, 3'b110, 4'b0001, 1, 0, 0, 1, "so_win");
        so_chk = 1'b0;
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clock);
        end
        if (q.size() > 0) begin
            total++;
            $display("FAIL drain: %0d pending, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
